lif_neuron: RTL
===============

# lif_neuron

Leaky integrate-and-fire neuron stage that sits directly downstream of the `mac` synaptic accumulator. Each time-step strobe it takes the accumulated synaptic current (`acc_out` of the MAC array), leaks and integrates it into a signed membrane potential, and emits a one-cycle output spike when the threshold is reached. After firing it enters a refractory period, and its spike output feeds the next layer's `spike_in`.

## Interface
- `THRESH`, 16'sd256: signed firing threshold; fire when the potential is ≥ `THRESH`.
- `LEAK_SHIFT`, 4: leak term is `v >>> LEAK_SHIFT`; legal range 1..15.
- `REFRACT`, 3: refractory length in time-step strobes; 0 means no refractory period (legal 0..15).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  time-step strobe; `in_current` is sampled only when this is high.
- `in_current`  in  16 signed  synaptic current, taken from MAC `acc_out`.
- `spike_out`  out  1  registered one-cycle fire pulse.
- `v_mem`  out  16 signed  registered membrane potential.
- `refractory`  out  1  high while the refractory counter is non-zero.
- `spike_count`  out  16  saturating fire count; present only with `LIF_SPIKE_COUNT_EN`.

## Operation
- Two states:
  - `ST_INTEG`: integrating.
  - `ST_REFRACT`: refractory.
- Reset values: `v_mem` = 0, `spike_out` = 0, `refractory` = 0, refractory counter = 0, state = `ST_INTEG`, `spike_count` = 0.
- `in_valid` low: all state holds, and `spike_out` is 0 on the next cycle.
- `ST_INTEG` with `in_valid` high:
  - Compute `v_next = v - (v >>> LEAK_SHIFT) + in_current` in 18-bit signed.
  - Saturate `v_next` to [-32768, 32767].
  - If saturated `v_next` ≥ `THRESH`: set `spike_out` to 1, set `v_mem` to 0, load the counter with `REFRACT`, and go to `ST_REFRACT` (stay in `ST_INTEG` if `REFRACT` is 0).
  - Otherwise set `v_mem` to saturated `v_next`.
- `ST_REFRACT` with `in_valid` high:
  - `in_current` is dropped, and `v_mem` stays at 0.
  - The counter decrements; when it reaches 0, return to `ST_INTEG`.
  - The strobe that takes the counter 1→0 is itself dropped.
- `refractory` equals (counter ≠ 0), registered.
- Leak uses an arithmetic shift, so negative potentials decay toward 0. -1 is a fixed point of the shift; -1 − (−1) = 0 on the next strobe.
- Threshold compare is on the saturated value; equality fires.
- `spike_count` (with `LIF_SPIKE_COUNT_EN`) increments on each fire and saturates at 16'hFFFF.

## Timing
- Latency: a strobe at edge N shows its result in `v_mem`, `spike_out` and `refractory` after edge N.
- `spike_out` is exactly one cycle wide, even if `in_valid` stays high continuously.
- Back-to-back strobes are accepted every cycle; there is no ready/backpressure, since the neuron always accepts.
- With `REFRACT` = R and strobes every cycle, the earliest re-fire is R+1 strobes after the fire strobe.
- `rst` asserted mid-operation (including mid-refractory): all outputs go to their reset values immediately, without waiting for a clock edge. The first strobe after deassertion integrates from `v` = 0 in `ST_INTEG`.

## Configuration
- `LIF_SPIKE_COUNT_EN` defined: the `spike_count` port and its 16-bit saturating counter exist. The counter is cleared only by `rst`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset:** hold `rst` = 1, toggle `in_valid` with `in_current` = 500 → `v_mem` = 0, `spike_out` = 0, `refractory` = 0 throughout.
- **Integrate and fire (defaults):** `in_current` = 100 on three consecutive strobes.
  - Required `v_mem` sequence: 100, 194, then 282 ≥ 256, so a fire.
  - After the third edge: `spike_out` = 1 for one cycle, `v_mem` = 0, `refractory` = 1.
- **Refractory:** after a fire, apply 3 strobes with `in_current` = 300 → `v_mem` stays 0, no spike, `refractory` falls after the 3rd. A 4th strobe of 300 → fire again.
- **Leak and hold:** from `v_mem` = 100, strobe with `in_current` = 0 → 94, then 89. `in_valid` low for 5 cycles → `v_mem` holds at 89.
- **Negative saturation:** `in_current` = -32768 on two strobes → `v_mem` = -32768 both times; no wrap to positive.
- **Async reset mid-refractory and counter:** fire, then pulse `rst` between clock edges → outputs clear immediately, with no clock edge needed. With `LIF_SPIKE_COUNT_EN`, two fires give `spike_count` = 2, and `rst` returns it to 0.

Source files
------------

// File: rtl/lif_neuron.sv
// ---------------------------------------------------------------------------
// lif_neuron -- leaky integrate-and-fire neuron stage.
//
// On each time-step strobe the neuron does the following:
//   - It leaks the membrane potential by an arithmetic right shift.
//   - It adds the synaptic current from the upstream MAC.
//   - It saturates the result to 16-bit signed.
// When the saturated potential reaches THRESH, the neuron emits a one-cycle
// spike, clears the potential and enters a refractory period of REFRACT
// strobes. During that period incoming current is discarded.
//
// Parameters:
//   THRESH      signed firing threshold (fire when potential >= THRESH)
//   LEAK_SHIFT  leak term is v >>> LEAK_SHIFT (1..15)
//   REFRACT     refractory length in strobes, 0 = none (0..15)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_valid     in   time-step strobe
//   in_current   in   16-bit signed synaptic current
//   spike_out    out  registered one-cycle fire pulse
//   v_mem        out  registered 16-bit signed membrane potential
//   refractory   out  high while the refractory counter is non-zero
//   spike_count  out  16-bit saturating fire count (only with the macro)
//
// Optional feature macro: LIF_SPIKE_COUNT_EN. When it is defined, the
// spike_count port and its counter are built.
// ---------------------------------------------------------------------------
module lif_neuron #(
  parameter logic signed [15:0] THRESH     = 16'sd256,
  parameter int                 LEAK_SHIFT = 4,
  parameter int                 REFRACT    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] in_current,
  output logic               spike_out,
  output logic signed [15:0] v_mem,
  output logic               refractory
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic        [15:0] spike_count
`endif
);

  typedef enum logic {
    ST_INTEG   = 1'b0,
    ST_REFRACT = 1'b1
  } state_t;

  localparam logic [3:0] REFRACT_C = 4'(REFRACT);

  state_t             state_q;
  logic signed [15:0] v_q;
  logic               spike_q;
  logic               refr_q;
  logic [3:0]         cnt_q;

  logic signed [17:0] v_ext_s;
  logic signed [17:0] leak_s;
  logic signed [17:0] cur_ext_s;
  logic signed [17:0] v_next_s;
  logic signed [15:0] v_sat_d;
  logic               fire_s;
  logic [3:0]         cnt_dec_s;

  // Leak, integrate and saturate; 18 bits hold the worst-case sum without wrap.
  always_comb begin
    v_ext_s   = {{2{v_q[15]}}, v_q};
    cur_ext_s = {{2{in_current[15]}}, in_current};
    leak_s    = v_ext_s >>> LEAK_SHIFT;
    v_next_s  = v_ext_s - leak_s + cur_ext_s;
    if (v_next_s > 18'sd32767) begin
      v_sat_d = 16'sh7FFF;
    end else if (v_next_s < -18'sd32768) begin
      v_sat_d = 16'sh8000;
    end else begin
      v_sat_d = v_next_s[15:0];
    end
    // Threshold is compared on the saturated value; equality fires.
    fire_s    = (v_sat_d >= THRESH);
    cnt_dec_s = cnt_q - 4'd1;
  end

  // Neuron state machine: potential, spike pulse and refractory countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INTEG;
      v_q     <= 16'sd0;
      spike_q <= 1'b0;
      refr_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      // The spike is a single-cycle pulse unless re-armed below.
      spike_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          ST_INTEG: begin
            if (fire_s) begin
              spike_q <= 1'b1;
              v_q     <= 16'sd0;
              cnt_q   <= REFRACT_C;
              refr_q  <= (REFRACT_C != 4'd0);
              state_q <= (REFRACT_C != 4'd0) ? ST_REFRACT : ST_INTEG;
            end else begin
              v_q <= v_sat_d;
            end
          end
          ST_REFRACT: begin
            // The current is discarded; the strobe that reaches 0 is dropped too.
            v_q    <= 16'sd0;
            cnt_q  <= cnt_dec_s;
            refr_q <= (cnt_dec_s != 4'd0);
            if (cnt_dec_s == 4'd0) begin
              state_q <= ST_INTEG;
            end else begin
              state_q <= ST_REFRACT;
            end
          end
          default: begin
            state_q <= ST_INTEG;
            v_q     <= 16'sd0;
            cnt_q   <= 4'd0;
            refr_q  <= 1'b0;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign spike_out  = spike_q;
  assign v_mem      = v_q;
  assign refractory = refr_q;

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] count_q;

  // Saturating fire counter; it is cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'd0;
    end else if (in_valid && (state_q == ST_INTEG) && fire_s &&
                 (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign spike_count = count_q;
`endif

endmodule
